// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD page sequencer: FSM states,
// HD44780-style command constants and the DDRAM row base table.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SET_ADDR = 2'd1,
    ST_WR_CHAR  = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_t;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;

  // DDRAM start address of each display line (4-line controllers interleave).
  localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_refresh_timer.sv
// Free-running period counter; tick is high for one cycle every PERIOD cycles.
module lcd_refresh_timer #(
  parameter int unsigned PERIOD = 8_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_page_sequencer.sv
// Renders a ROWS x COLS page from the character ROM into the LCD driver over a
// valid/ready byte interface. Periodic redraw is built in with LCD_SEQ_AUTO_REFRESH_EN.
module lcd_page_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned COLS        = 16,
  parameter int unsigned ROWS        = 2,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned REFRESH_CYC = 8_000_000,
  localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ID_W-1:0]  page_id,
  input  logic             refresh,
  output logic [ID_W-1:0]  rom_page,
  output logic [ROW_W-1:0] rom_row,
  output logic [COL_W-1:0] rom_col,
  input  logic [7:0]       rom_char,
  output logic             wr_valid,
  output logic             wr_rs,
  output logic [7:0]       wr_data,
  input  logic             wr_ready,
  output logic             busy,
  output logic             done
);

  // Write handshake: a byte moves on a rising edge where wr_valid && wr_ready.
  // wr_valid/wr_rs/wr_data are decoded from registered state and counters, so
  // they cannot change until that transfer happens; wr_valid never drops early.

  if (REFRESH_CYC == 0) begin : g_bad_period
    $error("REFRESH_CYC must be nonzero");
  end

  seq_state_t       state, state_nxt;
  logic [ID_W-1:0]  cur_page;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             pending;
  logic             tick;
  logic             trigger;
  logic             start_req;
  logic             launch;
  logic             accept;
  logic             last_col;
  logic             last_row;
  logic [1:0]       row_idx;

`ifdef LCD_SEQ_AUTO_REFRESH_EN
  lcd_refresh_timer #(
    .PERIOD (REFRESH_CYC)
  ) u_refresh_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );
`else
  assign tick = 1'b0;
`endif

  assign trigger   = (page_id != cur_page) || refresh || tick;
  assign start_req = trigger || pending;
  assign accept    = wr_valid && wr_ready;
  assign last_col  = (col == COL_W'(COLS - 1));
  assign last_row  = (row == ROW_W'(ROWS - 1));
  assign row_idx   = 2'(row);

  assign rom_page = cur_page;
  assign rom_row  = row;
  assign rom_col  = col;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          launch    = 1'b1;
          state_nxt = ST_SET_ADDR;
        end
      end
      ST_SET_ADDR: begin
        if (accept) state_nxt = ST_WR_CHAR;
      end
      ST_WR_CHAR: begin
        if (accept && last_col) state_nxt = last_row ? ST_DONE : ST_SET_ADDR;
      end
      ST_DONE: begin
        // A request that arrived during the render restarts without an idle cycle.
        if (start_req) begin
          launch    = 1'b1;
          state_nxt = ST_SET_ADDR;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_valid = 1'b0;
    wr_rs    = RS_CMD;
    wr_data  = 8'h00;
    case (state)
      ST_SET_ADDR: begin
        wr_valid = 1'b1;
        wr_rs    = RS_CMD;
        wr_data  = LCD_CMD_SET_DDRAM | ROW_BASE[row_idx];
      end
      ST_WR_CHAR: begin
        wr_valid = 1'b1;
        wr_rs    = RS_DATA;
        wr_data  = rom_char;
      end
      default: ;
    endcase
  end

  assign busy = (state == ST_SET_ADDR) || (state == ST_WR_CHAR);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_page <= '0;
      row      <= '0;
      col      <= '0;
      pending  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cur_page <= page_id;
        row      <= '0;
        col      <= '0;
        pending  <= 1'b0;
      end else begin
        if (state == ST_WR_CHAR && accept) begin
          if (!last_col) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            if (!last_row) row <= row + 1'b1;
          end
        end
        if (busy && trigger) pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/lcd_page_sequencer.md
# lcd_page_sequencer

Parametrised page writer for the character LCD path. It renders a complete ROWS x COLS text page from the character ROM into the LCD driver, using a valid/ready write handshake instead of a fixed-rate write strobe. Before each row it issues a DDRAM set-address command. A new render starts on a page change, on an explicit refresh request, or on a periodic timer. It sits between the exercise-selection logic, the character ROM and the nibble-level LCD driver.

## Interface
- COLS, 16: characters per row, 1..40
- ROWS, 2: display rows, 1..4
- ID_W, 4: width of page identifier
- REFRESH_CYC, 8_000_000: auto-refresh period in clk cycles (0.2 s at 40 MHz)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- page_id  in  ID_W  requested page (exercise) to display
- refresh  in  1  single-cycle request to redraw the current page
- rom_page  out  ID_W  page selector to character ROM
- rom_row  out  $clog2(ROWS) (min 1)  row selector to ROM
- rom_col  out  $clog2(COLS) (min 1)  column selector to ROM
- rom_char  in  8  ROM ASCII output, combinational from rom_* selectors
- wr_valid  out  1  write request to driver
- wr_rs  out  1  0 = command, 1 = character data
- wr_data  out  8  command or character byte
- wr_ready  in  1  driver can accept a byte
- busy  out  1  render in progress
- done  out  1  one-cycle pulse when a page completes

## Operation
- States: IDLE, SET_ADDR, WR_CHAR, DONE.
- **IDLE.** On a trigger, latch page_id into cur_page, clear row/col, go to SET_ADDR, set busy.
  - Triggers: page_id != cur_page, refresh, auto-refresh tick, or post-reset start.
- **SET_ADDR.** Present wr_rs=0 and wr_data = 8'h80 | ROW_BASE[row].
  - ROW_BASE = 00, 40, 14, 54 (hex).
  - On accept, go to WR_CHAR.
- **WR_CHAR.** Present wr_rs=1 and wr_data = rom_char at (cur_page, row, col).
  - On accept with col < COLS-1: col+1.
  - On accept with col = COLS-1 and row < ROWS-1: col=0, row+1, go to SET_ADDR.
  - On accept with the last cell: go to DONE.
- **DONE.** Pulse done and clear busy for one cycle, then return to IDLE.
  - If a trigger is pending, go straight back to SET_ADDR with a freshly latched page instead.
- **Handshake rules.**
  - A transfer occurs when wr_valid && wr_ready on a clock edge.
  - Once asserted, wr_valid, wr_rs and wr_data stay stable until accepted.
  - wr_valid is never deasserted without a transfer.
- **Triggers during a render** do not abort it.
  - A single pending flag is set; multiple requests merge into one redraw.
  - page_id is re-sampled at the restart.
- rom_page is driven from cur_page, never directly from page_id.
- Exactly ROWS*(COLS+1) transfers occur per page.

## Timing
- Reset values: wr_valid=0, wr_rs=0, wr_data=0, busy=0, done=0, rom_row=0, rom_col=0, cur_page=0, pending=1.
  - pending=1 forces one render after reset release.
- Trigger seen in IDLE at edge N: busy=1 and the first command is valid from N+1.
- With wr_ready held high: one transfer per cycle. Page latency from trigger = ROWS*(COLS+1)+1 cycles to the done pulse.
- done is asserted in the cycle after the final character transfer.
- Trigger and done coincide: the trigger is pended and serviced without an IDLE cycle.
- rst_n asserted mid-render: all outputs go to reset values immediately. Pending bytes are discarded and a full render starts after release.
- Row and column counters never wrap past ROWS-1 / COLS-1.

## Configuration
- LCD_SEQ_AUTO_REFRESH_EN defined:
  - A free-running counter issues a redraw trigger every REFRESH_CYC cycles.
  - The counter keeps running during a render; a tick then sets pending.
- Undefined: no refresh counter. Renders occur only on page change, refresh, or reset.

## Structure
- Shared package lcd_pkg holds:
  - state enum
  - LCD_CMD_SET_DDRAM = 8'h80
  - ROW_BASE constant array
  - RS_CMD/RS_DATA constants
- One sub-module, lcd_refresh_timer: parametrised period counter emitting a one-cycle tick. It is instantiated only under LCD_SEQ_AUTO_REFRESH_EN.

## Test plan
- Reset release, wr_ready=1, COLS=16, ROWS=2, page 3 → bytes 80, 16 chars, C0, 16 chars; done at cycle 35; busy low afterwards.
- wr_ready toggling randomly → wr_data/wr_rs held stable while valid&&!ready; byte sequence identical to the ready=1 run.
- page_id changes 3→5 mid-row-0 → page 3 completes, done pulses, page 5 render follows with no IDLE gap; rom_page=3 throughout the first render.
- Three refresh pulses during one render → exactly one extra render.
- rst_n low mid-render for 2 cycles → wr_valid=0 immediately; after release a full render starts with command 80.
- Macro defined, REFRESH_CYC=100, idle otherwise → a render begins every 100 cycles. Macro undefined → no renders after the first.
